freq_classifier_n: RTL and testbench

FREQ_CLASSIFIER_N -- requirements
Module: freq_classifier_n

---
 rtl/freq_classifier_n.sv | 143 ++++++++++++++
 tb/tb_freq_classifier_n.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_classifier_n.sv
// Per-channel square-wave period classifier: synchronizes each input, measures
// the clocks between rising edges, and reports a debounced band class.
module freq_classifier_n #(
  parameter int CHANNELS  = 3,
  parameter int CNT_W     = 21,
  parameter int TIMEOUT   = 1000000,
  parameter int BAND1_MIN = 180000,
  parameter int BAND1_MAX = 220000,
  parameter int BAND2_MIN = 36000,
  parameter int BAND2_MAX = 44000,
  parameter int MATCH_CNT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   sig_in,
  output logic [2*CHANNELS-1:0] class_out,
  output logic [CHANNELS-1:0]   change_strobe
);

  localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] B1_LO  = CNT_W'(BAND1_MIN);
  localparam logic [CNT_W-1:0] B1_HI  = CNT_W'(BAND1_MAX);
  localparam logic [CNT_W-1:0] B2_LO  = CNT_W'(BAND2_MIN);
  localparam logic [CNT_W-1:0] B2_HI  = CNT_W'(BAND2_MAX);
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [3:0]       MATCH_C = 4'(MATCH_CNT);

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_B1   = 2'b01;
  localparam logic [1:0] CLS_B2   = 2'b10;
  localparam logic [1:0] CLS_OUT  = 2'b11;

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] p);
    logic [1:0] c;
    if (p >= B1_LO && p <= B1_HI) begin
      c = CLS_B1;
    end else if (p >= B2_LO && p <= B2_HI) begin
      c = CLS_B2;
    end else begin
      c = CLS_OUT;
    end
    return c;
  endfunction

  // Edge detection stays blocked until the synchronizer and previous flops hold
  // real samples, so a level already high at reset release is not an edge.
  logic [2:0] live_r;

  // Post-reset warm-up shift register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live_r <= 3'b000;
    end else begin
      live_r <= {live_r[1:0], 1'b1};
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             sync1_r, sync2_r, prev_r, armed_r, strobe_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       cand_r, cls_r;
    logic [3:0]       run_r;

    logic             edge_s, armed_s, strobe_s;
    logic [CNT_W-1:0] cnt_s;
    logic [1:0]       cand_s, cls_s, meas_s;
    logic [3:0]       run_s;

    // Next-state: arming, period measurement, match filter and timeout
    always_comb begin
      edge_s   = sync2_r & ~prev_r & live_r[2];
      armed_s  = armed_r;
      cnt_s    = cnt_r;
      cand_s   = cand_r;
      run_s    = run_r;
      cls_s    = cls_r;
      strobe_s = 1'b0;
      meas_s   = classify(cnt_r);
      if (edge_s) begin
        cnt_s = ONE_C;
        if (!armed_r) begin
          armed_s = 1'b1;
        end else begin
          if (meas_s == cand_r) begin
            run_s = (run_r >= MATCH_C) ? MATCH_C : run_r + 4'd1;
          end else begin
            run_s = 4'd1;
          end
          cand_s = meas_s;
          if (run_s == MATCH_C && meas_s != cls_r) begin
            cls_s    = meas_s;
            strobe_s = 1'b1;
          end else begin
            cls_s = cls_r;
          end
        end
      end else if (armed_r) begin
        if (cnt_r == TO_C) begin
          armed_s  = 1'b0;
          cnt_s    = ZERO_C;
          run_s    = 4'd0;
          cand_s   = CLS_NONE;
          cls_s    = CLS_NONE;
          strobe_s = (cls_r != CLS_NONE);
        end else begin
          cnt_s = cnt_r + ONE_C;
        end
      end else begin
        cnt_s = cnt_r;
      end
    end

    // Channel state registers
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync1_r  <= 1'b0;
        sync2_r  <= 1'b0;
        prev_r   <= 1'b0;
        armed_r  <= 1'b0;
        cnt_r    <= ZERO_C;
        cand_r   <= CLS_NONE;
        run_r    <= 4'd0;
        cls_r    <= CLS_NONE;
        strobe_r <= 1'b0;
      end else begin
        sync1_r  <= sig_in[g];
        sync2_r  <= sync1_r;
        prev_r   <= sync2_r;
        armed_r  <= armed_s;
        cnt_r    <= cnt_s;
        cand_r   <= cand_s;
        run_r    <= run_s;
        cls_r    <= cls_s;
        strobe_r <= strobe_s;
      end
    end

    assign class_out[2*g+1:2*g] = cls_r;
    assign change_strobe[g]     = strobe_r;
  end

endmodule

// File: tb/tb_freq_classifier_n.sv
// Directed bench for freq_classifier_n with scaled-down period parameters.
module tb_freq_classifier_n;

  localparam int TO = 1000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic [5:0] class_out;
  logic [2:0] change_strobe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int scount [3] = '{0, 0, 0};
  int last_cyc0 = 0;

  freq_classifier_n #(
    .CHANNELS(3), .CNT_W(11), .TIMEOUT(TO),
    .BAND1_MIN(180), .BAND1_MAX(220),
    .BAND2_MIN(36), .BAND2_MAX(44),
    .MATCH_CNT(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sig_in({s2, s1, s0}),
    .class_out(class_out),
    .change_strobe(change_strobe)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (change_strobe[i]) scount[i] <= scount[i] + 1;
    end
    if (change_strobe[0]) last_cyc0 <= cyc;
  end

  typedef struct {
    string    name;
    int       period;
    logic [1:0] cls;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_sig(input int ch, input logic v);
    case (ch)
      0: s0 = v;
      1: s1 = v;
      default: s2 = v;
    endcase
  endtask

  // n rising edges, each followed by a full period
  task automatic train(input int ch, input int n, input int p);
    for (int i = 0; i < n; i++) begin
      set_sig(ch, 1'b1);
      repeat (p / 2) @(negedge clock);
      set_sig(ch, 1'b0);
      repeat (p - p / 2) @(negedge clock);
    end
  endtask

  task automatic close_rise(input int ch, input int p);
    set_sig(ch, 1'b1);
    repeat (p / 2) @(negedge clock);
    set_sig(ch, 1'b0);
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int b0, b1, b2, lock_cyc, waited;

    vecs[0]  = '{"p200",  200,  2'b01};
    vecs[1]  = '{"p180",  180,  2'b01};
    vecs[2]  = '{"p220",  220,  2'b01};
    vecs[3]  = '{"p179",  179,  2'b11};
    vecs[4]  = '{"p221",  221,  2'b11};
    vecs[5]  = '{"p36",   36,   2'b10};
    vecs[6]  = '{"p44",   44,   2'b10};
    vecs[7]  = '{"p40",   40,   2'b10};
    vecs[8]  = '{"p100",  100,  2'b11};
    vecs[9]  = '{"p45",   45,   2'b11};
    vecs[10] = '{"p35",   35,   2'b11};
    vecs[11] = '{"p_to",  TO,   2'b11};
    vecs[12] = '{"p_to1", TO+1, 2'b00};

    reset_dut();
    check("reset_class", int'(class_out), 0);
    check("reset_strobe", int'(change_strobe), 0);

    for (int v = 0; v < 13; v++) begin
      reset_dut();
      b0 = scount[0]; b1 = scount[1]; b2 = scount[2];
      train(0, 3, vecs[v].period);
      close_rise(0, vecs[v].period);
      repeat (5) @(negedge clock);
      check({vecs[v].name, "_class"}, int'(class_out[1:0]), int'(vecs[v].cls));
      check({vecs[v].name, "_strobes"}, scount[0] - b0, (vecs[v].cls != 2'b00) ? 1 : 0);
      check({vecs[v].name, "_idle"}, int'(class_out[5:2]) + scount[1] - b1 + scount[2] - b2, 0);
    end

    // exact latency of the first class change
    reset_dut();
    train(0, 3, 200);
    s0 = 1'b1;
    @(posedge clock); #1 check("lat_k", int'(class_out[1:0]), 0);
    @(posedge clock); #1 check("lat_k1", int'(class_out[1:0]), 0);
    @(posedge clock); #1 check("lat_k2_class", int'(class_out[1:0]), 1);
    check("lat_k2_strobe", int'(change_strobe[0]), 1);
    @(posedge clock); #1 check("lat_k3_strobe", int'(change_strobe[0]), 0);
    @(negedge clock); s0 = 1'b0;

    // concurrent channels
    reset_dut();
    b0 = scount[0]; b1 = scount[1]; b2 = scount[2];
    fork
      begin train(0, 3, 200); close_rise(0, 200); end
      begin train(1, 3, 40);  close_rise(1, 40);  end
      begin train(2, 3, 100); close_rise(2, 100); end
    join
    repeat (5) @(negedge clock);
    check("conc_class", int'(class_out), 6'b11_10_01);
    check("conc_strobes", (scount[0]-b0)*100 + (scount[1]-b1)*10 + (scount[2]-b2), 111);

    // alternating periods must not disturb a locked class
    reset_dut();
    b0 = scount[0];
    train(0, 4, 200);
    check("alt_lock", int'(class_out[1:0]), 1);
    train(0, 1, 40); train(0, 1, 200); train(0, 1, 40); train(0, 1, 200); train(0, 1, 40);
    check("alt_hold_class", int'(class_out[1:0]), 1);
    check("alt_hold_strobes", scount[0] - b0, 1);
    train(0, 2, 40);
    close_rise(0, 40);
    repeat (5) @(negedge clock);
    check("alt_switch_class", int'(class_out[1:0]), 2);
    check("alt_switch_strobes", scount[0] - b0, 2);

    // timeout after a static input, then re-acquisition
    reset_dut();
    train(0, 3, 200);
    close_rise(0, 200);
    repeat (5) @(negedge clock);
    check("to_lock", int'(class_out[1:0]), 1);
    lock_cyc = last_cyc0;
    b0 = scount[0];
    waited = 0;
    while (scount[0] == b0 && waited < TO + 200) begin
      @(negedge clock);
      waited++;
    end
    check("to_strobe_seen", scount[0] - b0, 1);
    check("to_delay", last_cyc0 - lock_cyc, TO);
    check("to_class", int'(class_out[1:0]), 0);
    train(0, 3, 200);
    check("to_restart3", int'(class_out[1:0]), 0);
    close_rise(0, 200);
    repeat (5) @(negedge clock);
    check("to_restart4", int'(class_out[1:0]), 1);

    // reset in the middle of a period
    reset_dut();
    train(0, 3, 200);
    close_rise(0, 200);
    repeat (30) @(negedge clock);
    check("mid_lock", int'(class_out[1:0]), 1);
    b0 = scount[0];
    #3 reset = 1'b1;
    #1 check("mid_async_clear", int'(class_out), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_no_strobe", scount[0] - b0, 0);
    train(0, 3, 200);
    close_rise(0, 200);
    repeat (5) @(negedge clock);
    check("mid_relock", int'(class_out[1:0]), 1);
    check("mid_relock_strobes", scount[0] - b0, 1);

    // high level at reset release is not an edge
    s0 = 1'b1;
    reset_dut();
    repeat (100) @(negedge clock);
    s0 = 1'b0;
    repeat (98) @(negedge clock);
    train(0, 2, 200);
    close_rise(0, 200);
    repeat (5) @(negedge clock);
    check("rel_high_no_edge", int'(class_out[1:0]), 0);
    repeat (95) @(negedge clock);
    close_rise(0, 200);
    repeat (5) @(negedge clock);
    check("rel_high_lock", int'(class_out[1:0]), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
